// File: rtl/data_mem_ctrl.sv
// Store-queue + single-port data RAM endpoint: buffers committed stores, drains them to RAM, serves loads with forwarding.
// Latency: load response 1 cycle after acceptance; stores reach RAM when drained (drain blocked by loads unless queue is full).
// Backpressure: mem_sb_ready_o drops when the queue is full; mem_ld_ready_o drops in the same cycles so the drain can make progress.
module data_mem_ctrl #(
  parameter int WORD_SIZE_P = 16,
  parameter int MEM_DEPTH   = 1024,
  parameter int WQ_ENTRY    = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   sb_mem_v_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
  output logic                   mem_sb_ready_o,
  input  logic                   ld_v_i,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  output logic                   mem_ld_ready_o,
  output logic                   mem_ld_v_o,
  output logic [WORD_SIZE_P-1:0] mem_ld_data_o,
  output logic                   mem_idle_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(WQ_ENTRY);
  localparam int CNT_W = PTR_W + 1;

  // Queue keeps only the RAM index: upper address bits never take part in a
  // compare or an access, so aliases behave identically in queue and RAM.
  logic [IDX_W-1:0]       wq_idx  [WQ_ENTRY];
  logic [WORD_SIZE_P-1:0] wq_data [WQ_ENTRY];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [PTR_W-1:0]       last;
  logic [CNT_W-1:0]       count;

  logic [WORD_SIZE_P-1:0] ram [MEM_DEPTH];
  logic [WORD_SIZE_P-1:0] ram_rdata;
  logic [IDX_W-1:0]       ram_addr;

  logic [IDX_W-1:0]       sb_idx;
  logic [IDX_W-1:0]       ld_idx;
  logic                   full;
  logic                   nonempty;
  logic                   ld_grant;
  logic                   drain;
  logic                   st_acc;
  logic                   st_coalesce;
  logic                   st_alloc;
  logic                   st_fwd;

  logic                   q_hit;
  logic [WORD_SIZE_P-1:0] q_dat;
  logic [PTR_W-1:0]       slot;
  logic                   fwd_hit_q;
  logic [WORD_SIZE_P-1:0] fwd_dat_q;

  if (WORD_SIZE_P > IDX_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{sb_mem_addr_i[WORD_SIZE_P-1:IDX_W], ld_addr_i[WORD_SIZE_P-1:IDX_W]};
  end

  assign sb_idx   = sb_mem_addr_i[IDX_W-1:0];
  assign ld_idx   = ld_addr_i[IDX_W-1:0];
  assign last     = tail - PTR_W'(1);

  // Arbitration works on registered count only; a full queue forces a drain.
  assign full     = (count == CNT_W'(WQ_ENTRY));
  assign nonempty = (count != '0);
  assign ld_grant = ld_v_i & ~full;
  assign drain    = full | (~ld_v_i & nonempty);

  assign mem_sb_ready_o = ~full;
  assign mem_ld_ready_o = ~full;
  assign mem_idle_o     = ~nonempty;

  // A store to the same index as the youngest entry merges into it, unless that
  // entry is the one leaving for RAM this cycle (count==1 and draining).
  assign st_acc      = sb_mem_v_i & ~full;
  assign st_coalesce = st_acc & nonempty & (wq_idx[last] == sb_idx)
                       & ~(drain & (count == CNT_W'(1)));
  assign st_alloc    = st_acc & ~st_coalesce;
  assign st_fwd      = st_acc & (sb_idx == ld_idx);

  // Youngest-match search: walk oldest to youngest so later hits override.
  always_comb begin
    q_hit = 1'b0;
    q_dat = '0;
    slot  = head;
    for (int i = 0; i < WQ_ENTRY; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (wq_idx[slot] == ld_idx)) begin
        q_hit = 1'b1;
        q_dat = wq_data[slot];
      end
    end
  end

  // Queue pointers and occupancy; reset discards all pending stores.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (st_alloc) tail <= tail + PTR_W'(1);
      if (drain)    head <= head + PTR_W'(1);
      count <= count + CNT_W'(st_alloc) - CNT_W'(drain);
    end
  end

  // Queue payload storage; contents are meaningless outside head..tail-1.
  always_ff @(posedge clk_i) begin
    if (st_alloc) begin
      wq_idx[tail]  <= sb_idx;
      wq_data[tail] <= sb_mem_data_i;
    end else if (st_coalesce) begin
      wq_data[last] <= sb_mem_data_i;
    end
  end

  assign ram_addr = drain ? wq_idx[head] : ld_idx;

  // Single-port RAM: drain write and load read are mutually exclusive; reset blocks the write.
  always_ff @(posedge clk_i) begin
    if (drain && reset_i) ram[ram_addr] <= wq_data[head];
    if (ld_grant)         ram_rdata     <= ram[ram_addr];
  end

  // Load response; forward source is captured in the request cycle. Reset
  // selects the forward path with zero data so mem_ld_data_o reads 0.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mem_ld_v_o <= 1'b0;
      fwd_hit_q  <= 1'b1;
      fwd_dat_q  <= '0;
    end else begin
      mem_ld_v_o <= ld_grant;
      if (ld_grant) begin
        fwd_hit_q <= st_fwd | q_hit;
        fwd_dat_q <= st_fwd ? sb_mem_data_i : q_dat;
      end
    end
  end

  assign mem_ld_data_o = fwd_hit_q ? fwd_dat_q : ram_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: store drain, forwarding, full-queue backpressure, coalescing, reset discard.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Every expected value below is hand-derived from the cycle behaviour of the block.
module tb_data_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        sb_mem_v_i;
  logic [15:0] sb_mem_addr_i;
  logic [15:0] sb_mem_data_i;
  logic        mem_sb_ready_o;
  logic        ld_v_i;
  logic [15:0] ld_addr_i;
  logic        mem_ld_ready_o;
  logic        mem_ld_v_o;
  logic [15:0] mem_ld_data_o;
  logic        mem_idle_o;

  int tests = 0;
  int fails = 0;

  data_mem_ctrl #(.WORD_SIZE_P(16), .MEM_DEPTH(1024), .WQ_ENTRY(4)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .sb_mem_v_i     (sb_mem_v_i),
    .sb_mem_addr_i  (sb_mem_addr_i),
    .sb_mem_data_i  (sb_mem_data_i),
    .mem_sb_ready_o (mem_sb_ready_o),
    .ld_v_i         (ld_v_i),
    .ld_addr_i      (ld_addr_i),
    .mem_ld_ready_o (mem_ld_ready_o),
    .mem_ld_v_o     (mem_ld_v_o),
    .mem_ld_data_o  (mem_ld_data_o),
    .mem_idle_o     (mem_idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    sb_mem_v_i    = 1'b1;
    sb_mem_addr_i = a;
    sb_mem_data_i = d;
    tick();
    sb_mem_v_i    = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; sb_mem_v_i = 1'b0; sb_mem_addr_i = '0; sb_mem_data_i = '0;
    ld_v_i = 1'b0; ld_addr_i = '0;
    tick(); tick();
    chk("rst_ld_v",     mem_ld_v_o,     0);
    chk("rst_ld_data",  mem_ld_data_o,  0);
    chk("rst_idle",     mem_idle_o,     1);
    chk("rst_sb_ready", mem_sb_ready_o, 1);
    chk("rst_ld_ready", mem_ld_ready_o, 1);
    reset_i = 1'b1;

    // Store then drain with no loads, then load from RAM.
    store(16'h010, 16'h1234);
    chk("t1_queued", mem_idle_o, 0);
    tick(); tick();
    chk("t1_ram",  dut.ram[10'h010], 16'h1234);
    chk("t1_idle", mem_idle_o, 1);
    ld_v_i = 1'b1; ld_addr_i = 16'h010;
    tick();
    ld_v_i = 1'b0;
    chk("t1_ld_v",    mem_ld_v_o,    1);
    chk("t1_ld_data", mem_ld_data_o, 16'h1234);
    tick();
    chk("t1_ld_v_drop", mem_ld_v_o,    0);
    chk("t1_ld_hold",   mem_ld_data_o, 16'h1234);

    // Same-cycle store and load to one address.
    sb_mem_v_i = 1'b1; sb_mem_addr_i = 16'h020; sb_mem_data_i = 16'hAAAA;
    ld_v_i = 1'b1; ld_addr_i = 16'h020;
    chk("t2_ld_ready", mem_ld_ready_o, 1);
    tick();
    sb_mem_v_i = 1'b0; ld_v_i = 1'b0;
    chk("t2_ld_v",    mem_ld_v_o,    1);
    chk("t2_ld_data", mem_ld_data_o, 16'hAAAA);
    tick(); tick();
    chk("t2_ram",  dut.ram[10'h020], 16'hAAAA);
    chk("t2_idle", mem_idle_o, 1);

    // Continuous loads starve the drain until the queue fills.
    ld_v_i = 1'b1; ld_addr_i = 16'h010;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_sb_ready_%0d", k), mem_sb_ready_o, 1);
      store(16'h030 + 16'(k), 16'hC000 + 16'(k));
    end
    chk("t3_full_sb_ready", mem_sb_ready_o, 0);
    chk("t3_full_ld_ready", mem_ld_ready_o, 0);
    chk("t3_full_count",    dut.count,      4);
    tick();
    chk("t3_sb_ready_back", mem_sb_ready_o, 1);
    chk("t3_ld_ready_back", mem_ld_ready_o, 1);
    chk("t3_count_3",       dut.count,      3);
    chk("t3_head_ram",      dut.ram[10'h030], 16'hC000);
    chk("t3_ld_refused",    mem_ld_v_o,     0);
    ld_v_i = 1'b0;
    repeat (4) tick();
    chk("t3_idle",     mem_idle_o, 1);
    chk("t3_tail_ram", dut.ram[10'h033], 16'hC003);

    // Back-to-back stores to one address coalesce.
    ld_v_i = 1'b1; ld_addr_i = 16'h010;
    store(16'h040, 16'h1111);
    store(16'h040, 16'h2222);
    chk("t4_count", dut.count, 1);
    ld_addr_i = 16'h040;
    tick();
    chk("t4_ld_v",    mem_ld_v_o,    1);
    chk("t4_ld_data", mem_ld_data_o, 16'h2222);
    ld_v_i = 1'b0;
    repeat (3) tick();
    chk("t4_ram",  dut.ram[10'h040], 16'h2222);
    chk("t4_idle", mem_idle_o, 1);

    // Non-adjacent repeat address: no coalesce, youngest match forwards.
    ld_v_i = 1'b1; ld_addr_i = 16'h010;
    store(16'h050, 16'h0001);
    store(16'h051, 16'h0002);
    store(16'h050, 16'h0003);
    chk("t5_count", dut.count, 3);
    ld_addr_i = 16'h050;
    tick();
    chk("t5_youngest", mem_ld_data_o, 16'h0003);
    ld_addr_i = 16'h051;
    tick();
    chk("t5_other", mem_ld_data_o, 16'h0002);
    ld_v_i = 1'b0;
    repeat (4) tick();
    chk("t5_ram50", dut.ram[10'h050], 16'h0003);
    chk("t5_ram51", dut.ram[10'h051], 16'h0002);

    // Reset with three pending stores discards them.
    ld_v_i = 1'b1; ld_addr_i = 16'h010;
    store(16'h050, 16'hDEAD);
    store(16'h051, 16'hBEEF);
    store(16'h030, 16'hF00D);
    chk("t6_count", dut.count, 3);
    ld_addr_i = 16'h050;
    tick();
    chk("t6_fwd", mem_ld_data_o, 16'hDEAD);
    reset_i = 1'b0; ld_v_i = 1'b0;
    tick();
    reset_i = 1'b1;
    chk("t6_idle",     mem_idle_o,     1);
    chk("t6_ld_v",     mem_ld_v_o,     0);
    chk("t6_sb_ready", mem_sb_ready_o, 1);
    chk("t6_ld_data",  mem_ld_data_o,  0);
    chk("t6_count0",   dut.count,      0);
    repeat (4) tick();
    chk("t6_ram50", dut.ram[10'h050], 16'h0003);
    chk("t6_ram51", dut.ram[10'h051], 16'h0002);
    chk("t6_ram30", dut.ram[10'h030], 16'hC000);
    ld_v_i = 1'b1; ld_addr_i = 16'h050;
    tick();
    ld_v_i = 1'b0;
    chk("t6_ld_after", mem_ld_data_o, 16'h0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-side endpoint of the store-buffer-to-memory interface. Accepts committed stores (addr/data), holds them in a small circular write queue, and drains them into a single-port synchronous data RAM.
- Also serves execute-stage loads through the same RAM port. Loads forward from the queue so they always see the newest committed data.
- Adds a ready back-pressure signal toward the store buffer, so a committed store is never dropped.

Parameters:
- WORD_SIZE_P, 16, data and address word width.
- MEM_DEPTH, 1024, RAM words. Power of 2. RAM index = addr[$clog2(MEM_DEPTH)-1:0], upper bits ignored.
- WQ_ENTRY, 4, write queue depth. Power of 2, ≥2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset.
- sb_mem_v_i  in  1  committed store valid.
- sb_mem_addr_i  in  WORD_SIZE_P  store word address.
- sb_mem_data_i  in  WORD_SIZE_P  store data.
- mem_sb_ready_o  out  1  queue can accept a store this cycle.
- ld_v_i  in  1  load request valid.
- ld_addr_i  in  WORD_SIZE_P  load word address.
- mem_ld_ready_o  out  1  load accepted this cycle.
- mem_ld_v_o  out  1  load response valid (registered).
- mem_ld_data_o  out  WORD_SIZE_P  load response data (registered).
- mem_idle_o  out  1  write queue empty.

Behaviour:
- State:
  - Queue entries {addr, data}.
  - head and tail pointers, $clog2(WQ_ENTRY) bits, wrap modulo WQ_ENTRY.
  - count, $clog2(WQ_ENTRY)+1 bits, range 0..WQ_ENTRY.
- Reset (reset_i==0 at posedge):
  - count=0, head=tail=0, mem_ld_v_o=0, mem_ld_data_o=0.
  - RAM contents are not reset.
  - Reset has priority over every other event, mid-drain included; queued stores are discarded.
- mem_sb_ready_o = (count != WQ_ENTRY). Combinational from registered count only; the same-cycle drain is not considered.
- Store accept: sb_mem_v_i & mem_sb_ready_o.
  - Coalesce: if count>0, addr == queue[tail-1].addr, and that entry is not being popped this cycle, overwrite its data. Pointers and count unchanged.
  - Otherwise: write queue[tail], tail++, count++.
- RAM port arbitration, one access per cycle, evaluated on registered state:
  - count==WQ_ENTRY (full): drain wins. mem_ld_ready_o=0. Write queue[head] to RAM, head++, count--.
  - else if ld_v_i: load wins. mem_ld_ready_o=1. RAM read at ld index. No drain.
  - else if count>0: drain head.
  - else: idle.
  - mem_ld_ready_o=0 only when the queue is full.
- Simultaneous accept (allocating) and drain: count unchanged, both pointers advance.
- Load response, latency 1:
  - Cycle after an accepted load: mem_ld_v_o=1. Otherwise mem_ld_v_o=0; mem_ld_data_o holds its last value.
  - Data priority, evaluated in the request cycle:
    - (a) Store accepted in the same cycle with an equal masked address.
    - (b) Youngest valid queue entry with an equal masked address, searched from tail-1 back to head.
    - (c) RAM read data.
  - The forward hit flag and data are registered in the request cycle and muxed against RAM output in the response cycle.
- Address compare uses the masked RAM index, so aliases match consistently with RAM.
- mem_idle_o = (count==0).
- Ordering invariant: RAM writes occur in queue order. A load never returns data older than any store accepted at or before its request cycle.

Test Plan:
- Reset, then store A=0x010 D=0x1234, no loads for 2 cycles; load 0x010 -> mem_ld_v_o=1 next cycle, data 0x1234 from RAM; mem_idle_o=1.
- Store 0x020 D=0xAAAA while ld_v_i=1 on 0x020 in the same cycle -> response 0xAAAA via same-cycle forward; RAM later holds 0xAAAA.
- Hold ld_v_i=1 every cycle and issue 4 stores to 0x30..0x33 -> count reaches 4, mem_sb_ready_o=0, mem_ld_ready_o=0 that cycle, head drains; next cycle mem_sb_ready_o=1 and mem_ld_ready_o=1.
- Store 0x040 D=0x1111 then 0x040 D=0x2222 back-to-back with loads blocking drain -> count=1 (coalesced); load 0x040 returns 0x2222; after drain, RAM[0x040]=0x2222.
- Stores 0x050 D=1 then 0x051 D=2 then 0x050 D=3 (no coalesce, count=3); load 0x050 -> 3 (youngest match).
- Fill queue with 3 entries, assert reset_i=0 for one cycle -> count=0, mem_idle_o=1, mem_ld_v_o=0, mem_sb_ready_o=1; no RAM writes from the discarded entries.
